led_scan_arbiter: RTL and testbench
===================================

LED_SCAN_ARBITER -- requirements
Module: led_scan_arbiter

Interface
REQ-001 Parameter HOLD, default 4: grant length in cycles; legal range 1..255.
REQ-002 Parameter MODE, default 0: 0 drives the latched nibble to LED unchanged; 1 drives its bitwise inverse.
REQ-003 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ  input  4  per-channel request; bit i is channel i.
REQ-006 VAL  input  16  channel data; channel i on VAL[4i+3:4i].
REQ-007 LED  output  4  shared LED bus, registered.
REQ-008 GNT  output  4  one-hot grant, registered; all-zero when no channel owns the bus.
REQ-009 BUSY  output  1  high in GRANT and RELEASE.
REQ-010 DONE  output  1  one-cycle pulse in RELEASE.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and RELEASE.
REQ-012 IDLE: with REQ nonzero, the FSM SHALL select the first requesting channel after LAST in cyclic order (LAST+1, LAST+2, ... mod 4); next cycle it is in GRANT.
REQ-013 On the IDLE->GRANT edge:
- GNT SHALL become the winner's one-hot bit.
- LED SHALL load the winner's VAL nibble, MODE applied.
- The 8-bit hold counter SHALL load HOLD-1.
REQ-014 LED SHALL hold the latched nibble for the whole grant; VAL changes during GRANT SHALL NOT reach LED.
REQ-015 GRANT: while the winner's REQ is high and the counter is nonzero, the counter SHALL decrement each cycle; GRANT therefore lasts exactly HOLD cycles when REQ stays high.
REQ-016 GRANT exits to RELEASE on the first of:
- the counter at zero;
- the winner's REQ sampled low (early release).
REQ-017 RELEASE lasts exactly one cycle:
- GNT=0, LED=0, DONE=1;
- LAST SHALL update to the winner index;
- next state IDLE.
REQ-018 Minimum spacing between two grants is two cycles (RELEASE, IDLE); there is no back-to-back grant.
REQ-019 Requests from non-granted channels during GRANT SHALL be ignored; there is no preemption.
REQ-020 REQ=0 in IDLE: the FSM SHALL stay in IDLE with GNT=0, LED=0, DONE=0.
REQ-021 GNT SHALL never have more than one bit set.
REQ-022 HOLD=1: GRANT lasts one cycle.

Reset
REQ-023 RST high at any clock edge, including mid-GRANT, SHALL force:
- state=IDLE, LED=0, GNT=0, BUSY=0, DONE=0;
- counter=0, LAST=3, so channel 0 wins first.
REQ-024 A grant interrupted by reset SHALL produce no DONE pulse.
REQ-025 The first grant decision SHALL occur on the first edge after RST is sampled low.

Configuration
REQ-026 Macro LED_ARB_PRIO0_EN defined: in IDLE, channel 0 SHALL win whenever REQ[0]=1, regardless of LAST; the other channels stay round-robin among themselves; there is no preemption of an active grant.
REQ-027 Macro LED_ARB_PRIO0_EN undefined: pure round-robin per REQ-012.

Verification
REQ-028 Reset, then REQ=0001, VAL[3:0]=0xA, MODE=0, HOLD=4 -> GNT=0001 and LED=0xA one cycle later for 4 cycles; then one RELEASE cycle with GNT=0, LED=0, DONE=1.
REQ-029 REQ=1111 held continuously, HOLD=2 -> grants cycle 0001, 0010, 0100, 1000, 0001; each grant lasts 2 cycles, with 2 cycles between grants.
REQ-030 MODE=1, VAL[7:4]=0x3, REQ=0010 -> LED=0xC during the grant.
REQ-031 REQ[2] granted with HOLD=8, REQ[2] dropped after 3 GRANT cycles -> RELEASE on the next cycle with DONE=1; LAST=2, so the next REQ=1111 grants channel 3.
REQ-032 RST pulsed mid-GRANT -> next cycle all outputs 0 with no DONE; REQ=1111 then grants channel 0 first.
REQ-033 With LED_ARB_PRIO0_EN, LAST=0 and REQ=0011 held -> channel 0 wins every arbitration; without it, grants alternate 0010, 0001.

Source files
------------

// File: rtl/led_scan_arbiter_if.sv
// Handshake/bus bundle for led_scan_arbiter: per-channel requests and data in,
// shared LED bus, one-hot grant and status out.
interface led_scan_arbiter_if;
  logic [3:0]  REQ;
  logic [15:0] VAL;
  logic [3:0]  LED;
  logic [3:0]  GNT;
  logic        BUSY;
  logic        DONE;

  modport master (output REQ, VAL, input LED, GNT, BUSY, DONE);
  modport slave  (input REQ, VAL, output LED, GNT, BUSY, DONE);
endinterface

// File: rtl/led_scan_arbiter.sv
// Round-robin arbiter granting one of four channels the shared LED bus for HOLD cycles.
// Define LED_ARB_PRIO0_EN to make channel 0 win every arbitration it requests.
module led_scan_arbiter #(
  parameter int HOLD = 4,
  parameter int MODE = 0
) (
  input logic              CLK,
  input logic              RST,
  led_scan_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] last;
  logic [1:0] owner;
  logic [3:0] cand;
  logic [1:0] win;
  logic [1:0] idx;
  logic [3:0] nibble;

`ifdef LED_ARB_PRIO0_EN
  // Channel 0 masks everyone else; without it, 1..3 rotate among themselves.
  always_comb begin
    cand = bus.REQ[0] ? 4'b0001 : (bus.REQ & 4'b1110);
  end
`else
  always_comb begin
    cand = bus.REQ;
  end
`endif

  // Scan from farthest to nearest so the first requester after last wins.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (cand[idx]) begin
        win = idx;
      end
    end
  end

  assign nibble = bus.VAL[{win, 2'b00} +: 4];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      last     <= 2'd3;
      owner    <= 2'd0;
      bus.LED  <= 4'd0;
      bus.GNT  <= 4'd0;
      bus.BUSY <= 1'b0;
      bus.DONE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.DONE <= 1'b0;
          if (|cand) begin
            state    <= GRANT;
            owner    <= win;
            bus.GNT  <= 4'b0001 << win;
            bus.LED  <= (MODE == 1) ? ~nibble : nibble;
            cnt      <= HOLD_LOAD;
            bus.BUSY <= 1'b1;
          end
        end
        GRANT: begin
          // LED stays latched; only expiry or the owner dropping its request ends the grant.
          if (cnt == 8'd0 || !bus.REQ[owner]) begin
            state    <= RELEASE;
            bus.GNT  <= 4'd0;
            bus.LED  <= 4'd0;
            bus.DONE <= 1'b1;
            last     <= owner;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RELEASE: begin
          state    <= IDLE;
          bus.BUSY <= 1'b0;
          bus.DONE <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_arbiter.sv
// Directed bench for led_scan_arbiter: four instances with different HOLD/MODE
// settings, driven one scenario at a time with hand-computed expectations.
module tb_led_scan_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  led_scan_arbiter_if a_bus ();
  led_scan_arbiter_if b_bus ();
  led_scan_arbiter_if c_bus ();
  led_scan_arbiter_if d_bus ();

  led_scan_arbiter #(.HOLD(4), .MODE(0)) dut_a (.CLK(CLK), .RST(RST), .bus(a_bus.slave));
  led_scan_arbiter #(.HOLD(2), .MODE(1)) dut_b (.CLK(CLK), .RST(RST), .bus(b_bus.slave));
  led_scan_arbiter #(.HOLD(8), .MODE(0)) dut_c (.CLK(CLK), .RST(RST), .bus(c_bus.slave));
  led_scan_arbiter #(.HOLD(1), .MODE(0)) dut_d (.CLK(CLK), .RST(RST), .bus(d_bus.slave));

  always #5 CLK = ~CLK;

`ifdef LED_ARB_PRIO0_EN
  localparam logic [3:0] RR_EXP [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
  localparam logic [3:0] ALT_FIRST  = 4'b0001;
  localparam logic [3:0] C_AFTER_G  = 4'b0001;
  localparam logic [3:0] C_AFTER_L  = 4'h0;
`else
  localparam logic [3:0] RR_EXP [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  localparam logic [3:0] ALT_FIRST  = 4'b0010;
  localparam logic [3:0] C_AFTER_G  = 4'b1000;
  localparam logic [3:0] C_AFTER_L  = 4'h1;
`endif

  function automatic logic [15:0] pack(input logic [3:0] g, input logic [3:0] l,
                                       input logic b, input logic d);
    return {4'h0, g, l, 2'b00, b, d};
  endfunction

  function automatic logic [15:0] stA();
    return pack(a_bus.GNT, a_bus.LED, a_bus.BUSY, a_bus.DONE);
  endfunction
  function automatic logic [15:0] stB();
    return pack(b_bus.GNT, b_bus.LED, b_bus.BUSY, b_bus.DONE);
  endfunction
  function automatic logic [15:0] stC();
    return pack(c_bus.GNT, c_bus.LED, c_bus.BUSY, c_bus.DONE);
  endfunction
  function automatic logic [15:0] stD();
    return pack(d_bus.GNT, d_bus.LED, d_bus.BUSY, d_bus.DONE);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    a_bus.REQ = 4'd0; a_bus.VAL = 16'd0;
    b_bus.REQ = 4'd0; b_bus.VAL = 16'd0;
    c_bus.REQ = 4'd0; c_bus.VAL = 16'd0;
    d_bus.REQ = 4'd0; d_bus.VAL = 16'd0;
    applyStimulus(2);
    checkOutput("reset_a", stA(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    checkOutput("reset_b", stB(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    checkOutput("reset_c", stC(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    checkOutput("reset_d", stD(), pack(4'd0, 4'd0, 1'b0, 1'b0));

    // Single channel 0 grant, HOLD=4; VAL change mid-grant must not reach LED.
    RST = 1'b0;
    a_bus.REQ = 4'b0001;
    a_bus.VAL = 16'h000A;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1);
      checkOutput("a_grant", stA(), pack(4'b0001, 4'hA, 1'b1, 1'b0));
      if (i == 1) a_bus.VAL = 16'h0005;
    end
    applyStimulus(1);
    checkOutput("a_release", stA(), pack(4'd0, 4'd0, 1'b1, 1'b1));
    a_bus.REQ = 4'd0;
    applyStimulus(1);
    checkOutput("a_idle", stA(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1);
    checkOutput("a_idle_noreq", stA(), pack(4'd0, 4'd0, 1'b0, 1'b0));

    // LAST=0, REQ=0011 held: alternation (or channel 0 always with priority).
    a_bus.REQ = 4'b0011;
    a_bus.VAL = 16'h0021;
    applyStimulus(1);
    checkOutput("a_alt_first", {12'd0, a_bus.GNT}, {12'd0, ALT_FIRST});
    applyStimulus(6);
    checkOutput("a_alt_second", {12'd0, a_bus.GNT}, 16'h0001);
    a_bus.REQ = 4'd0;
    applyStimulus(1);
    checkOutput("a_alt_early_rel", stA(), pack(4'd0, 4'd0, 1'b1, 1'b1));
    applyStimulus(1);
    checkOutput("a_alt_idle", stA(), pack(4'd0, 4'd0, 1'b0, 1'b0));

    // HOLD=1: one grant cycle, then RELEASE and IDLE before the next grant.
    d_bus.REQ = 4'b0100;
    d_bus.VAL = 16'h0700;
    applyStimulus(1);
    checkOutput("d_grant1", stD(), pack(4'b0100, 4'h7, 1'b1, 1'b0));
    applyStimulus(1);
    checkOutput("d_release1", stD(), pack(4'd0, 4'd0, 1'b1, 1'b1));
    applyStimulus(1);
    checkOutput("d_gap", stD(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    applyStimulus(1);
    checkOutput("d_grant2", stD(), pack(4'b0100, 4'h7, 1'b1, 1'b0));
    d_bus.REQ = 4'd0;
    applyStimulus(1);
    checkOutput("d_release2", stD(), pack(4'd0, 4'd0, 1'b1, 1'b1));

    // HOLD=2, MODE=1, REQ=1111: rotation with two-cycle gaps; VAL=0 shows as LED=F.
    b_bus.REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      applyStimulus(1);
      checkOutput("b_rr_grant", stB(), pack(RR_EXP[g], 4'hF, 1'b1, 1'b0));
      applyStimulus(1);
      checkOutput("b_rr_hold", stB(), pack(RR_EXP[g], 4'hF, 1'b1, 1'b0));
      applyStimulus(1);
      checkOutput("b_rr_release", stB(), pack(4'd0, 4'd0, 1'b1, 1'b1));
      applyStimulus(1);
      checkOutput("b_rr_idle", stB(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    end

    // MODE=1 inversion: VAL[7:4]=3 shows as LED=C.
    b_bus.REQ = 4'b0010;
    b_bus.VAL = 16'h0030;
    applyStimulus(1);
    checkOutput("b_inv_grant", stB(), pack(4'b0010, 4'hC, 1'b1, 1'b0));
    applyStimulus(1);
    checkOutput("b_inv_hold", stB(), pack(4'b0010, 4'hC, 1'b1, 1'b0));
    b_bus.REQ = 4'd0;
    applyStimulus(1);
    checkOutput("b_inv_release", stB(), pack(4'd0, 4'd0, 1'b1, 1'b1));

    // HOLD=8, channel 2 drops after three grant cycles.
    c_bus.REQ = 4'b0100;
    c_bus.VAL = 16'h1900;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("c_grant", stC(), pack(4'b0100, 4'h9, 1'b1, 1'b0));
    end
    c_bus.REQ = 4'd0;
    applyStimulus(1);
    checkOutput("c_early_release", stC(), pack(4'd0, 4'd0, 1'b1, 1'b1));
    applyStimulus(1);
    checkOutput("c_idle", stC(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    c_bus.REQ = 4'b1111;
    applyStimulus(1);
    checkOutput("c_after_last2", stC(), pack(C_AFTER_G, C_AFTER_L, 1'b1, 1'b0));

    // Reset mid-grant: everything clears with no DONE, then channel 0 wins first.
    RST = 1'b1;
    applyStimulus(1);
    checkOutput("c_mid_reset", stC(), pack(4'd0, 4'd0, 1'b0, 1'b0));
    RST = 1'b0;
    applyStimulus(1);
    checkOutput("c_post_reset", stC(), pack(4'b0001, 4'h0, 1'b1, 1'b0));
    applyStimulus(1);
    checkOutput("c_post_reset_hold", stC(), pack(4'b0001, 4'h0, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
